performance_ch_erase_avg_calc: RTL and testbench

Downstream consumer of the per-channel erase counter in the performance monitor. It waits for the counter to report a full sample window, then captures the accumulated erase-busy cycle sum and the completed-request count. A multi-cycle restoring divider computes the average erase latency, and the block updates the bus-visible statistics registers. It then returns a one-cycle copy-complete pulse so the counter clears and re-arms.

---
 rtl/performance_ch_erase_avg_calc.sv | 149 ++++++++++++++
 tb/tb_performance_ch_erase_avg_calc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/performance_ch_erase_avg_calc.sv
// Per-channel erase latency averager: captures a completed counter window, divides
// busy cycles by request count with a serial restoring divider, and updates statistics.
module performance_ch_erase_avg_calc #(
  parameter int unsigned DATA_WD = 32,
  parameter int unsigned REQ_WD  = 10,
  parameter int unsigned SMP_WD  = 16
) (
  input  logic               i_bus_clk,
  input  logic               i_bus_rst_n,
  input  logic               i_erase_ready,
  input  logic [DATA_WD-1:0] i_erase_cnt,
  input  logic [REQ_WD-1:0]  i_erase_req_cnt,
  input  logic               i_clear,
  output logic               o_erase_cnt_cp_cmplt,
  output logic [DATA_WD-1:0] o_avg_latency,
  output logic [DATA_WD-1:0] o_max_avg,
  output logic [SMP_WD-1:0]  o_sample_cnt,
  output logic               o_avg_valid,
  output logic               o_busy
);

  localparam int unsigned STEP_WD = $clog2(DATA_WD);
  localparam logic [STEP_WD-1:0] STEP_LAST = STEP_WD'(DATA_WD - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIVIDE    = 2'd1,
    UPDATE    = 2'd2,
    WAIT_DROP = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_WD-1:0]   dvd_q, dvd_d;
  logic [DATA_WD-1:0]   dvs_q, dvs_d;
  logic [DATA_WD:0]     rem_q, rem_d;
  logic [DATA_WD-1:0]   quo_q, quo_d;
  logic [STEP_WD-1:0]   step_q, step_d;
  logic [DATA_WD-1:0]   avg_q, avg_d;
  logic [DATA_WD-1:0]   max_q, max_d;
  logic [SMP_WD-1:0]    smp_q, smp_d;
  logic                 avg_valid_q, avg_valid_d;
  logic                 cmplt_q, cmplt_d;

  logic [DATA_WD:0]     rem_sh;
  logic                 rem_ge;

  // State and datapath registers
  always_ff @(posedge i_bus_clk or negedge i_bus_rst_n) begin
    if (!i_bus_rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      step_q      <= '0;
      avg_q       <= '0;
      max_q       <= '0;
      smp_q       <= '0;
      avg_valid_q <= 1'b0;
      cmplt_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      step_q      <= step_d;
      avg_q       <= avg_d;
      max_q       <= max_d;
      smp_q       <= smp_d;
      avg_valid_q <= avg_valid_d;
      cmplt_q     <= cmplt_d;
    end
  end

  // One restoring step: dividend is shifted out MSB first into the remainder
  assign rem_sh = {rem_q[DATA_WD-1:0], dvd_q[DATA_WD-1]};
  assign rem_ge = (rem_sh >= {1'b0, dvs_q});

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    step_d      = step_q;
    avg_d       = avg_q;
    max_d       = max_q;
    smp_d       = smp_q;
    avg_valid_d = 1'b0;
    cmplt_d     = 1'b0;

    if (i_clear && (state_q != UPDATE)) begin
      avg_d = '0;
      max_d = '0;
      smp_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (i_erase_ready) begin
          dvd_d   = i_erase_cnt;
          dvs_d   = DATA_WD'(i_erase_req_cnt);
          rem_d   = '0;
          quo_d   = '0;
          step_d  = STEP_LAST;
          state_d = (i_erase_req_cnt != '0) ? DIVIDE : UPDATE;
        end
      end
      DIVIDE: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        quo_d = {quo_q[DATA_WD-2:0], rem_ge};
        if (step_q == '0) begin
          state_d = UPDATE;
        end else begin
          step_d = step_q - STEP_WD'(1);
        end
      end
      UPDATE: begin
        avg_d = quo_q;
        // A coincident clear restarts the statistics with this window as the first sample
        if (i_clear) begin
          max_d = quo_q;
          smp_d = SMP_WD'(1);
        end else begin
          if (quo_q > max_q) max_d = quo_q;
          if (smp_q != '1) smp_d = smp_q + SMP_WD'(1);
        end
        avg_valid_d = 1'b1;
        cmplt_d     = 1'b1;
        state_d     = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!i_erase_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_erase_cnt_cp_cmplt = cmplt_q;
  assign o_avg_latency        = avg_q;
  assign o_max_avg            = max_q;
  assign o_sample_cnt         = smp_q;
  assign o_avg_valid          = avg_valid_q;
  assign o_busy               = (state_q != IDLE);

endmodule

// File: tb/tb_performance_ch_erase_avg_calc.sv
// Directed scoreboard bench for performance_ch_erase_avg_calc.
module tb_performance_ch_erase_avg_calc;

  localparam int unsigned DATA_WD = 32;
  localparam int unsigned REQ_WD  = 10;
  localparam int unsigned SMP_WD  = 16;

  logic               i_bus_clk;
  logic               i_bus_rst_n;
  logic               i_erase_ready;
  logic [DATA_WD-1:0] i_erase_cnt;
  logic [REQ_WD-1:0]  i_erase_req_cnt;
  logic               i_clear;
  logic               o_erase_cnt_cp_cmplt;
  logic [DATA_WD-1:0] o_avg_latency;
  logic [DATA_WD-1:0] o_max_avg;
  logic [SMP_WD-1:0]  o_sample_cnt;
  logic               o_avg_valid;
  logic               o_busy;

  performance_ch_erase_avg_calc #(
    .DATA_WD(DATA_WD), .REQ_WD(REQ_WD), .SMP_WD(SMP_WD)
  ) dut (
    .i_bus_clk            (i_bus_clk),
    .i_bus_rst_n          (i_bus_rst_n),
    .i_erase_ready        (i_erase_ready),
    .i_erase_cnt          (i_erase_cnt),
    .i_erase_req_cnt      (i_erase_req_cnt),
    .i_clear              (i_clear),
    .o_erase_cnt_cp_cmplt (o_erase_cnt_cp_cmplt),
    .o_avg_latency        (o_avg_latency),
    .o_max_avg            (o_max_avg),
    .o_sample_cnt         (o_sample_cnt),
    .o_avg_valid          (o_avg_valid),
    .o_busy               (o_busy)
  );

  initial i_bus_clk = 1'b0;
  always #5 i_bus_clk = ~i_bus_clk;

  typedef struct {
    logic [DATA_WD-1:0] avg;
    logic [DATA_WD-1:0] max;
    logic [SMP_WD-1:0]  smp;
    int                 lat;
  } exp_t;

  exp_t               exp_q[$];
  int                 n_vec;
  int                 n_fail;
  logic [DATA_WD-1:0] m_max;
  logic [SMP_WD-1:0]  m_smp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: truncating division plus max/sample bookkeeping
  task automatic push_expect(input logic [DATA_WD-1:0] cnt, input logic [REQ_WD-1:0] req,
                             input bit clr);
    exp_t               e;
    logic [DATA_WD-1:0] qv;
    qv = (req == '0) ? '0 : cnt / {{(DATA_WD-REQ_WD){1'b0}}, req};
    if (clr) begin
      m_max = qv;
      m_smp = 16'd1;
    end else begin
      if (qv > m_max) m_max = qv;
      if (m_smp != 16'hFFFF) m_smp = m_smp + 16'd1;
    end
    e.avg = qv;
    e.max = m_max;
    e.smp = m_smp;
    e.lat = (req == '0) ? 1 : 33;
    exp_q.push_back(e);
  endtask

  task automatic drive_window(input logic [DATA_WD-1:0] cnt, input logic [REQ_WD-1:0] req,
                              input bit clr);
    @(negedge i_bus_clk);
    i_erase_cnt     = cnt;
    i_erase_req_cnt = req;
    i_erase_ready   = 1'b1;
    push_expect(cnt, req, clr);
  endtask

  // Wait for the result pulse, compare against the scoreboard, then hold and drop ready
  task automatic await_result(input int clr_cyc, input int hold);
    int   cyc;
    int   extra;
    bit   seen;
    exp_t e;
    cyc   = 0;
    extra = 0;
    seen  = 1'b0;
    while (cyc < 100 && !seen) begin
      @(negedge i_bus_clk);
      cyc++;
      i_clear = (cyc == clr_cyc);
      if (cyc == 1) chk("busy_after_capture", 64'(o_busy), 64'd1);
      if (cyc == 3) begin
        i_erase_cnt     = ~i_erase_cnt;
        i_erase_req_cnt = 10'd1;
      end
      if (o_avg_valid) seen = 1'b1;
    end
    i_clear = 1'b0;
    chk("avg_valid_seen", 64'(seen), 64'd1);
    e = exp_q.pop_front();
    chk("latency", 64'(cyc - 1), 64'(e.lat));
    chk("ack_with_valid", 64'(o_erase_cnt_cp_cmplt), 64'd1);
    chk("avg_latency", 64'(o_avg_latency), 64'(e.avg));
    chk("max_avg", 64'(o_max_avg), 64'(e.max));
    chk("sample_cnt", 64'(o_sample_cnt), 64'(e.smp));
    for (int i = 0; i < hold; i++) begin
      @(negedge i_bus_clk);
      if (o_avg_valid || o_erase_cnt_cp_cmplt) extra++;
    end
    chk("single_pulse", 64'(extra), 64'd0);
    chk("busy_in_wait_drop", 64'(o_busy), 64'd1);
    i_erase_ready = 1'b0;
    @(negedge i_bus_clk);
    chk("idle_after_drop", 64'(o_busy), 64'd0);
  endtask

  initial begin
    int extra;
    n_vec           = 0;
    n_fail          = 0;
    m_max           = '0;
    m_smp           = '0;
    i_bus_rst_n     = 1'b0;
    i_erase_ready   = 1'b0;
    i_erase_cnt     = '0;
    i_erase_req_cnt = '0;
    i_clear         = 1'b0;
    repeat (3) @(negedge i_bus_clk);
    chk("rst_avg", 64'(o_avg_latency), 64'd0);
    chk("rst_max", 64'(o_max_avg), 64'd0);
    chk("rst_smp", 64'(o_sample_cnt), 64'd0);
    chk("rst_valid", 64'(o_avg_valid), 64'd0);
    chk("rst_ack", 64'(o_erase_cnt_cp_cmplt), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    i_bus_rst_n = 1'b1;
    @(negedge i_bus_clk);

    // Basic window, truncation, full-scale, zero divisor, long ready hold
    drive_window(32'd1000, 10'd10, 1'b0);       await_result(-1, 2);
    drive_window(32'd999, 10'd10, 1'b0);        await_result(-1, 2);
    drive_window(32'hFFFF_FFFF, 10'd1, 1'b0);   await_result(-1, 2);
    drive_window(32'd500, 10'd0, 1'b0);         await_result(-1, 2);
    drive_window(32'd12345, 10'd7, 1'b0);       await_result(-1, 20);

    // Clear while idle
    @(negedge i_bus_clk);
    i_clear = 1'b1;
    @(negedge i_bus_clk);
    i_clear = 1'b0;
    m_max   = '0;
    m_smp   = '0;
    chk("clear_avg", 64'(o_avg_latency), 64'd0);
    chk("clear_max", 64'(o_max_avg), 64'd0);
    chk("clear_smp", 64'(o_sample_cnt), 64'd0);

    // Clear coincident with UPDATE of the third window
    drive_window(32'd3000, 10'd10, 1'b0);       await_result(-1, 2);
    drive_window(32'd500, 10'd10, 1'b0);        await_result(-1, 2);
    drive_window(32'd700, 10'd10, 1'b1);        await_result(33, 2);

    // Reset in the middle of a division, ready kept high across release
    drive_window(32'd7777, 10'd3, 1'b0);
    extra = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge i_bus_clk);
      if (o_avg_valid || o_erase_cnt_cp_cmplt) extra++;
    end
    i_bus_rst_n = 1'b0;
    #1;
    chk("midrst_no_ack", 64'(extra), 64'd0);
    chk("midrst_avg", 64'(o_avg_latency), 64'd0);
    chk("midrst_max", 64'(o_max_avg), 64'd0);
    chk("midrst_smp", 64'(o_sample_cnt), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_ack", 64'(o_erase_cnt_cp_cmplt), 64'd0);
    void'(exp_q.pop_front());
    m_max = '0;
    m_smp = '0;
    repeat (2) @(negedge i_bus_clk);
    i_bus_rst_n = 1'b1;
    push_expect(32'd7777, 10'd3, 1'b0);
    await_result(-1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
